round_sequencer: RTL

- Clocked front-end controller that drives the AES round-stepping display path.
- Replaces direct use of the pushbutton as a clock with a synchronised, debounced, single-pulse step on the system clock.
- Latches the key-size mode and produces the registered round index, phase (cipher/decipher) and done flags that the cipher/decipher instances and the BCD/7-segment display consume.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/round_sequencer_if.sv | 27 ++
 rtl/key_debouncer.sv | 49 ++++
 rtl/round_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: key-size mode encodings, round counts,
// sequencer state type and the switch decode helpers.
package aes_pkg;

   localparam int ROUND_W = 5;

   typedef enum logic [1:0] {
      MODE_128 = 2'd0,
      MODE_192 = 2'd1,
      MODE_256 = 2'd2
   } mode_t;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic [1:0] {
      IDLE,
      CIPHER,
      DECIPHER,
      DONE
   } state_t;

   // 192-bit request wins over 256-bit request when both switches are up.
   function automatic mode_t decode_mode(input logic [1:0] sw);
      if (sw[0])
         return MODE_192;
      else if (sw[1])
         return MODE_256;
      else
         return MODE_128;
   endfunction

   function automatic logic [3:0] nr_of(input mode_t m);
      case (m)
         MODE_192: return NR_192;
         MODE_256: return NR_256;
         default:  return NR_128;
      endcase
   endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Bundle of the raw operator inputs and the registered round/display outputs
// of the round sequencer.
interface round_sequencer_if;
   import aes_pkg::*;

   logic               key_n;
   logic               sw_clear;
   logic [1:0]         sw_mode;
   logic               step_pulse;
   logic [1:0]         mode;
   logic [3:0]         nr;
   logic [ROUND_W-1:0] round;
   logic               phase;
   logic [3:0]         phase_round;
   logic               done;

   modport master (
      output key_n, sw_clear, sw_mode,
      input  step_pulse, mode, nr, round, phase, phase_round, done
   );

   modport slave (
      input  key_n, sw_clear, sw_mode,
      output step_pulse, mode, nr, round, phase, phase_round, done
   );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchroniser, debounce filter and single-cycle press detector for
// an active-low pushbutton.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   logic             key_s1_reg;
   logic             key_s2_reg;
   logic             stable_reg;
   logic             press_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             accept;

   // The counter only runs while the synchronised level disagrees with the
   // accepted level; any return to agreement restarts the qualification.
   assign accept = (key_s2_reg != stable_reg) &&
                   (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_reg <= 1'b1;
         key_s2_reg <= 1'b1;
         stable_reg <= 1'b1;
         cnt_reg    <= '0;
         press_reg  <= 1'b0;
      end else begin
         key_s1_reg <= key_n;
         key_s2_reg <= key_s1_reg;
         press_reg  <= accept && !key_s2_reg;
         if (key_s2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (accept) begin
            stable_reg <= key_s2_reg;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/round_sequencer.sv
// Steps the AES round index through the cipher and decipher phases on each
// debounced key press, with a latched key-size mode and synchronous clear.
module round_sequencer
   import aes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   round_sequencer_if.slave  bus
);

   logic               step;
   logic               clear_s1_reg;
   logic               clear_s2_reg;
   logic [1:0]         sw_s1_reg;
   logic [1:0]         sw_s2_reg;

   state_t             state_reg,       state_next;
   logic [ROUND_W-1:0] round_reg,       round_next;
   mode_t              mode_reg,        mode_next;
   logic [3:0]         nr_reg,          nr_next;
   logic               phase_reg,       phase_next;
   logic [3:0]         phase_round_reg, phase_round_next;
   logic               done_reg,        done_next;
   logic [ROUND_W-1:0] last_round;

   key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_key_debouncer (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key_n),
      .press (step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clear_s1_reg <= 1'b0;
         clear_s2_reg <= 1'b0;
         sw_s1_reg    <= 2'b00;
         sw_s2_reg    <= 2'b00;
      end else begin
         clear_s1_reg <= bus.sw_clear;
         clear_s2_reg <= clear_s1_reg;
         sw_s1_reg    <= bus.sw_mode;
         sw_s2_reg    <= sw_s1_reg;
      end
   end

   assign last_round = {nr_reg, 1'b0} + 5'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         round_reg       <= '0;
         mode_reg        <= MODE_128;
         nr_reg          <= NR_128;
         phase_reg       <= 1'b0;
         phase_round_reg <= '0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         round_reg       <= round_next;
         mode_reg        <= mode_next;
         nr_reg          <= nr_next;
         phase_reg       <= phase_next;
         phase_round_reg <= phase_round_next;
         done_reg        <= done_next;
      end
   end

   // Clear has priority over a coincident step in every state.
   always_comb begin
      state_next = state_reg;
      round_next = round_reg;
      if (clear_s2_reg) begin
         state_next = IDLE;
         round_next = '0;
      end else if (step) begin
         case (state_reg)
            IDLE: begin
               state_next = CIPHER;
               round_next = 5'd1;
            end
            CIPHER: begin
               round_next = round_reg + 5'd1;
               if (round_reg == {1'b0, nr_reg})
                  state_next = DECIPHER;
            end
            DECIPHER: begin
               round_next = round_reg + 5'd1;
               if (round_reg + 5'd1 == last_round)
                  state_next = DONE;
            end
            default: ;
         endcase
      end
   end

   // Mode follows the switches only while idle, including the edge that
   // leaves idle, so the first press captures the current selection.
   always_comb begin
      mode_next        = (state_reg == IDLE) ? decode_mode(sw_s2_reg) : mode_reg;
      nr_next          = nr_of(mode_next);
      phase_next       = (state_next == DECIPHER) || (state_next == DONE);
      phase_round_next = phase_next ? 4'(round_next - {1'b0, nr_next} - 5'd1)
                                    : 4'(round_next);
      done_next        = (state_next == DONE);
   end

   assign bus.step_pulse  = step;
   assign bus.mode        = mode_reg;
   assign bus.nr          = nr_reg;
   assign bus.round       = round_reg;
   assign bus.phase       = phase_reg;
   assign bus.phase_round = phase_round_reg;
   assign bus.done        = done_reg;

endmodule
